// File: rtl/tri_port_arbiter_if.sv
// Request/acknowledge bundle for the three client ports (L, M, R) of tri_port_arbiter.
// The master side issues requests; the slave side (the arbiter) returns acks and read data.
interface tri_port_arbiter_if #(
  parameter int no_addr_lines = 4,
  parameter int wordsize      = 8
);
  logic                     L_req;
  logic                     L_wr;
  logic [no_addr_lines-1:0] L_addr;
  logic [wordsize-1:0]      L_wdata;
  logic                     L_ack;
  logic [wordsize-1:0]      L_rdata;

  logic                     M_req;
  logic                     M_wr;
  logic [no_addr_lines-1:0] M_addr;
  logic [wordsize-1:0]      M_wdata;
  logic                     M_ack;
  logic [wordsize-1:0]      M_rdata;

  logic                     R_req;
  logic                     R_wr;
  logic [no_addr_lines-1:0] R_addr;
  logic [wordsize-1:0]      R_wdata;
  logic                     R_ack;
  logic [wordsize-1:0]      R_rdata;

  modport master (
    output L_req, L_wr, L_addr, L_wdata, input L_ack, L_rdata,
    output M_req, M_wr, M_addr, M_wdata, input M_ack, M_rdata,
    output R_req, R_wr, R_addr, R_wdata, input R_ack, R_rdata
  );

  modport slave (
    input L_req, L_wr, L_addr, L_wdata, output L_ack, L_rdata,
    input M_req, M_wr, M_addr, M_wdata, output M_ack, M_rdata,
    input R_req, R_wr, R_addr, R_wdata, output R_ack, R_rdata
  );
endinterface

// File: rtl/tri_port_arbiter.sv
// Three-port arbiter in front of a tri-ported RAM cell matrix; rotating priority on address conflicts.
// Optional macro TRI_PORT_ARB_CONFLICT_CNT_EN adds a saturating conflict_count output.
module tri_port_arbiter #(
  parameter int N             = 16,
  parameter int no_addr_lines = 4,
  parameter int wordsize      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tri_port_arbiter_if.slave        bus,
  output logic [no_addr_lines-1:0] L_address,
  output logic [no_addr_lines-1:0] M_address,
  output logic [no_addr_lines-1:0] R_address,
  output logic                     Left_Write,
  output logic                     Middle_Write,
  output logic                     Right_Write,
  output logic [wordsize-1:0]      L_Data_Bit_Line,
  output logic [wordsize-1:0]      M_Data_Bit_Line,
  output logic [wordsize-1:0]      R_Data_Bit_Line,
  input  logic [wordsize-1:0]      L_Data_Bit_Line_read,
  input  logic [wordsize-1:0]      M_Data_Bit_Line_read,
  input  logic [wordsize-1:0]      R_Data_Bit_Line_read
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]              conflict_count
`endif
);

  if (N != (1 << no_addr_lines)) begin : g_bad_size
    $error("tri_port_arbiter: N must equal 2**no_addr_lines");
  end

  // Port index 0 = L, 1 = M, 2 = R throughout.
  function automatic logic [1:0] rot(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  function automatic logic clash(input logic wr_a, input logic wr_b,
                                 input logic [no_addr_lines-1:0] addr_a,
                                 input logic [no_addr_lines-1:0] addr_b);
    return (addr_a == addr_b) && (wr_a || wr_b);
  endfunction

  logic [2:0]               req_s;
  logic [2:0]               wr_s;
  logic [no_addr_lines-1:0] addr_s [3];
  logic [wordsize-1:0]      wdata_s [3];
  logic [wordsize-1:0]      rd_line_s [3];
  logic [1:0]               ord_s [3];
  logic [2:0]               elig_s;
  logic [2:0]               grant_s;
  logic [2:0]               lose_s;
  logic                     blk_s;
  logic                     conflict_s;
  logic [1:0]               ptr_nxt_s;

  logic [1:0]               ptr_r;
  logic [2:0]               in_flight_r;
  logic [2:0]               ack_r;
  logic [2:0]               we_r;
  logic [no_addr_lines-1:0] address_r [3];
  logic [wordsize-1:0]      line_r [3];
  logic [wordsize-1:0]      rdata_r [3];

  // Gather the per-port interface signals into indexable arrays.
  always_comb begin
    req_s        = {bus.R_req, bus.M_req, bus.L_req};
    wr_s         = {bus.R_wr, bus.M_wr, bus.L_wr};
    addr_s[0]    = bus.L_addr;
    addr_s[1]    = bus.M_addr;
    addr_s[2]    = bus.R_addr;
    wdata_s[0]   = bus.L_wdata;
    wdata_s[1]   = bus.M_wdata;
    wdata_s[2]   = bus.R_wdata;
    rd_line_s[0] = L_Data_Bit_Line_read;
    rd_line_s[1] = M_Data_Bit_Line_read;
    rd_line_s[2] = R_Data_Bit_Line_read;
  end

  // Priority order starting at the pointer.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ord_s[k] = rot(ptr_r, 2'(k));
    end
  end

  // Grant in priority order; a port loses only to a higher-priority granted port it clashes with.
  always_comb begin
    elig_s  = req_s & ~in_flight_r;
    grant_s = 3'b000;
    lose_s  = 3'b000;
    blk_s   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      blk_s = 1'b0;
      for (int j = 0; j < k; j++) begin
        blk_s = blk_s | (grant_s[ord_s[j]] &
                clash(wr_s[ord_s[j]], wr_s[ord_s[k]], addr_s[ord_s[j]], addr_s[ord_s[k]]));
      end
      grant_s[ord_s[k]] = elig_s[ord_s[k]] & ~blk_s;
      lose_s[ord_s[k]]  = elig_s[ord_s[k]] & blk_s;
    end
  end

  // Any loser means a conflict; the highest-priority loser becomes the next pointer.
  always_comb begin
    conflict_s = |lose_s;
    ptr_nxt_s  = ptr_r;
    for (int k = 2; k >= 0; k--) begin
      ptr_nxt_s = lose_s[ord_s[k]] ? ord_s[k] : ptr_nxt_s;
    end
  end

  // Per-port transaction pipeline: grant edge drives the matrix, next edge captures data and acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= 2'd0;
      in_flight_r <= 3'b000;
      ack_r       <= 3'b000;
      we_r        <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        address_r[i] <= '0;
        line_r[i]    <= '0;
        rdata_r[i]   <= '0;
      end
    end else begin
      ptr_r <= ptr_nxt_s;
      for (int i = 0; i < 3; i++) begin
        in_flight_r[i] <= grant_s[i];
        ack_r[i]       <= in_flight_r[i];
        if (grant_s[i]) begin
          address_r[i] <= addr_s[i];
          we_r[i]      <= wr_s[i];
          line_r[i]    <= wdata_s[i];
        end else begin
          we_r[i] <= 1'b0;
        end
        // A write leaves the previous read data in place.
        if (in_flight_r[i] && !we_r[i]) begin
          rdata_r[i] <= rd_line_s[i];
        end else begin
          rdata_r[i] <= rdata_r[i];
        end
      end
    end
  end

`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_r;

  // Saturating count of edges on which some eligible port lost arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_r <= 16'h0000;
    end else if (conflict_s && (conflict_cnt_r != 16'hFFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 16'h0001;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_count = conflict_cnt_r;
`else
  logic unused_conflict_s;
  assign unused_conflict_s = conflict_s;
`endif

  assign bus.L_ack     = ack_r[0];
  assign bus.M_ack     = ack_r[1];
  assign bus.R_ack     = ack_r[2];
  assign bus.L_rdata   = rdata_r[0];
  assign bus.M_rdata   = rdata_r[1];
  assign bus.R_rdata   = rdata_r[2];
  assign L_address       = address_r[0];
  assign M_address       = address_r[1];
  assign R_address       = address_r[2];
  assign Left_Write      = we_r[0];
  assign Middle_Write    = we_r[1];
  assign Right_Write     = we_r[2];
  assign L_Data_Bit_Line = line_r[0];
  assign M_Data_Bit_Line = line_r[1];
  assign R_Data_Bit_Line = line_r[2];

endmodule

// File: tb/tb_tri_port_arbiter.sv
// Directed bench for tri_port_arbiter with a behavioural tri-port RAM attached to the matrix ports.
module tb_tri_port_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] L_address, M_address, R_address;
  logic       Left_Write, Middle_Write, Right_Write;
  logic [7:0] L_Data_Bit_Line, M_Data_Bit_Line, R_Data_Bit_Line;
  logic [7:0] L_Data_Bit_Line_read, M_Data_Bit_Line_read, R_Data_Bit_Line_read;
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_count;
`endif

  logic [7:0] mem [16];
  int n_cmp;
  int n_bad;

  tri_port_arbiter_if #(.no_addr_lines(4), .wordsize(8)) bus ();

  tri_port_arbiter #(.N(16), .no_addr_lines(4), .wordsize(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus),
    .L_address            (L_address),
    .M_address            (M_address),
    .R_address            (R_address),
    .Left_Write           (Left_Write),
    .Middle_Write         (Middle_Write),
    .Right_Write          (Right_Write),
    .L_Data_Bit_Line      (L_Data_Bit_Line),
    .M_Data_Bit_Line      (M_Data_Bit_Line),
    .R_Data_Bit_Line      (R_Data_Bit_Line),
    .L_Data_Bit_Line_read (L_Data_Bit_Line_read),
    .M_Data_Bit_Line_read (M_Data_Bit_Line_read),
    .R_Data_Bit_Line_read (R_Data_Bit_Line_read)
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
    ,
    .conflict_count       (conflict_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM cell matrix: combinational reads, writes on the rising edge.
  assign L_Data_Bit_Line_read = mem[L_address];
  assign M_Data_Bit_Line_read = mem[M_address];
  assign R_Data_Bit_Line_read = mem[R_address];

  always @(posedge clk) begin
    if (Left_Write)   mem[L_address] <= L_Data_Bit_Line;
    if (Middle_Write) mem[M_address] <= M_Data_Bit_Line;
    if (Right_Write)  mem[R_address] <= R_Data_Bit_Line;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic wr,
                       input logic [3:0] addr, input logic [7:0] data);
    case (port)
      0: begin bus.L_req = req; bus.L_wr = wr; bus.L_addr = addr; bus.L_wdata = data; end
      1: begin bus.M_req = req; bus.M_wr = wr; bus.M_addr = addr; bus.M_wdata = data; end
      2: begin bus.R_req = req; bus.R_wr = wr; bus.R_addr = addr; bus.R_wdata = data; end
      default: ;
    endcase
  endtask

  task automatic drop(input int port);
    drive(port, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[5] = 8'h3C;
    rst_n = 1'b0;
    drop(0); drop(1); drop(2);
    cyc(); cyc();
    chk("rst_acks", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b000);
    chk("rst_we", {Left_Write, Middle_Write, Right_Write}, 3'b000);
    chk("rst_addr", {L_address, M_address, R_address}, 12'h000);
    chk("rst_rdata", {bus.L_rdata, bus.M_rdata, bus.R_rdata}, 24'h000000);
    rst_n = 1'b1;

    // L write addr 3 = A5, then read it back
    drive(0, 1'b1, 1'b1, 4'h3, 8'hA5);
    cyc();
    chk("wr_we_pulse", {Left_Write, Middle_Write, Right_Write}, 3'b100);
    chk("wr_addr", L_address, 4'h3);
    chk("wr_data", L_Data_Bit_Line, 8'hA5);
    chk("wr_no_early_ack", bus.L_ack, 1'b0);
    cyc();
    chk("wr_ack", bus.L_ack, 1'b1);
    chk("wr_we_off", Left_Write, 1'b0);
    drop(0);
    cyc();
    chk("wr_ack_one_cycle", bus.L_ack, 1'b0);
    chk("wr_mem", mem[3], 8'hA5);
    drive(0, 1'b1, 1'b0, 4'h3, 8'h00);
    cyc();
    chk("rd_no_we", Left_Write, 1'b0);
    cyc();
    chk("rd_ack", bus.L_ack, 1'b1);
    chk("rd_data", bus.L_rdata, 8'hA5);
    drop(0);
    cyc();

    // Three reads of the same word are granted together
    drive(0, 1'b1, 1'b0, 4'h5, 8'h00);
    drive(1, 1'b1, 1'b0, 4'h5, 8'h00);
    drive(2, 1'b1, 1'b0, 4'h5, 8'h00);
    cyc();
    chk("rrr_no_ack_yet", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b000);
    cyc();
    chk("rrr_acks", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b111);
    chk("rrr_data", {bus.L_rdata, bus.M_rdata, bus.R_rdata}, 24'h3C3C3C);
    drop(0); drop(1); drop(2);
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
    chk("rrr_cnt", conflict_count, 16'd0);
`endif
    cyc();

    // L and R write addr 2 with ptr = L
    drive(0, 1'b1, 1'b1, 4'h2, 8'h11);
    drive(2, 1'b1, 1'b1, 4'h2, 8'h22);
    cyc();
    chk("lr_first", {Left_Write, Middle_Write, Right_Write}, 3'b100);
    cyc();
    chk("lr_second", {Left_Write, Middle_Write, Right_Write}, 3'b001);
    chk("lr_lack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b100);
    chk("lr_rdata_hold", bus.L_rdata, 8'h3C);
    drop(0);
    cyc();
    chk("lr_rack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b001);
    drop(2);
    cyc();
    chk("lr_mem", mem[2], 8'h22);
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
    chk("lr_cnt", conflict_count, 16'd1);
`endif

    // Same pair again: pointer is now R, so R wins
    drive(0, 1'b1, 1'b1, 4'h9, 8'h44);
    drive(2, 1'b1, 1'b1, 4'h9, 8'h55);
    cyc();
    chk("ptr_r_first", {Left_Write, Middle_Write, Right_Write}, 3'b001);
    cyc();
    chk("ptr_r_second", {Left_Write, Middle_Write, Right_Write}, 3'b100);
    chk("ptr_r_rack", bus.R_ack, 1'b1);
    drop(2);
    cyc();
    chk("ptr_r_lack", bus.L_ack, 1'b1);
    drop(0);
    cyc();
    chk("ptr_r_mem", mem[9], 8'h44);

    // Three-way write conflict on addr 7 (ptr = L)
    drive(0, 1'b1, 1'b1, 4'h7, 8'h01);
    drive(1, 1'b1, 1'b1, 4'h7, 8'h02);
    drive(2, 1'b1, 1'b1, 4'h7, 8'h03);
    cyc();
    chk("w3_e0_we", {Left_Write, Middle_Write, Right_Write}, 3'b100);
    chk("w3_e0_ack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b000);
    cyc();
    chk("w3_e1_we", {Left_Write, Middle_Write, Right_Write}, 3'b010);
    chk("w3_e1_ack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b100);
    drop(0);
    cyc();
    chk("w3_e2_we", {Left_Write, Middle_Write, Right_Write}, 3'b001);
    chk("w3_e2_ack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b010);
    drop(1);
    cyc();
    chk("w3_e3_we", {Left_Write, Middle_Write, Right_Write}, 3'b000);
    chk("w3_e3_ack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b001);
    drop(2);
    cyc();
    chk("w3_mem", mem[7], 8'h03);
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
    chk("w3_cnt", conflict_count, 16'd4);
`endif

    // Reset between grant and ack of an M read
    drive(1, 1'b1, 1'b0, 4'h5, 8'h00);
    cyc();
    chk("mrst_granted", M_address, 4'h5);
    rst_n = 1'b0;
    drop(1);
    #1;
    chk("mrst_ack", bus.M_ack, 1'b0);
    chk("mrst_addr", {L_address, M_address, R_address}, 12'h000);
    chk("mrst_lines", {L_Data_Bit_Line, M_Data_Bit_Line, R_Data_Bit_Line}, 24'h000000);
    chk("mrst_rdata", {bus.L_rdata, bus.M_rdata, bus.R_rdata}, 24'h000000);
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
    chk("mrst_cnt", conflict_count, 16'd0);
`endif
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mrst_no_ack", {bus.L_ack, bus.M_ack, bus.R_ack}, 3'b000);
    end

    // Pointer back at L after reset: L beats R
    drive(0, 1'b1, 1'b1, 4'h4, 8'h66);
    drive(2, 1'b1, 1'b1, 4'h4, 8'h77);
    cyc();
    chk("rst_ptr_l", {Left_Write, Middle_Write, Right_Write}, 3'b100);
    cyc();
    chk("rst_ptr_r2", Right_Write, 1'b1);
    drop(0);
    cyc();
    drop(2);
    cyc();
    chk("rst_ptr_mem", mem[4], 8'h77);

    // M loses to L, then withdraws before being granted
    drive(0, 1'b1, 1'b1, 4'h1, 8'h88);
    drive(1, 1'b1, 1'b1, 4'h1, 8'h99);
    cyc();
    chk("wd_first", {Left_Write, Middle_Write, Right_Write}, 3'b100);
    drop(1);
    cyc();
    chk("wd_m_idle", {Middle_Write, bus.M_ack}, 2'b00);
    chk("wd_lack", bus.L_ack, 1'b1);
    drop(0);
    cyc();
    chk("wd_no_mack", bus.M_ack, 1'b0);
    chk("wd_mem", mem[1], 8'h88);
`ifdef TRI_PORT_ARB_CONFLICT_CNT_EN
    chk("wd_cnt", conflict_count, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
